// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle EX-stage divider.
package div_pkg;

  localparam int DIV_W        = 32;
  localparam int DIV_ITERS    = 32;
  localparam int DIV_LATENCY  = 35;
  localparam int DIV0_LATENCY = 2;
  localparam int CNT_W        = $clog2(DIV_ITERS);
  localparam logic [DIV_W-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } div_state_t;

  // Two's-complement negate when neg is set; wraps at DIV_W bits.
  function automatic logic [DIV_W-1:0] cond_neg(input logic [DIV_W-1:0] v, input logic neg);
    return neg ? (~v + {{(DIV_W-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on magnitudes; purely combinational.
// No handshake: the caller registers the result each RUN cycle.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_W-1:0] rem,
  input  logic [DIV_W-1:0] quo,
  input  logic [DIV_W-1:0] dvs,
  output logic [DIV_W-1:0] rem_nxt,
  output logic [DIV_W-1:0] quo_nxt
);

  logic [DIV_W:0] shifted;
  logic           ge;

  assign shifted = {rem, quo[DIV_W-1]};
  assign ge      = (shifted >= {1'b0, dvs});

  // When ge holds the difference is below dvs, so a DIV_W-bit subtract is exact.
  always_comb begin
    rem_nxt = shifted[DIV_W-1:0];
    quo_nxt = {quo[DIV_W-2:0], 1'b0};
    if (ge) begin
      rem_nxt = shifted[DIV_W-1:0] - dvs;
      quo_nxt = {quo[DIV_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// DIV/DIVU sequencer: 35 cycles from acceptance to done (2 for divide-by-zero).
// Holds the pipeline via stall while busy; flush cancels any state before DONE.
module div_seq_ctrl
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sign,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [DIV_W-1:0] q,
  output logic [DIV_W-1:0] r
);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] dividend_l;
  logic [DIV_W-1:0] divisor_l;
  logic             sign_l;
  logic             neg_q;
  logic             neg_r;
  logic [DIV_W-1:0] rem;
  logic [DIV_W-1:0] quo;
  logic [DIV_W-1:0] dvs;
  logic [DIV_W-1:0] rem_nxt;
  logic [DIV_W-1:0] quo_nxt;

  div_step u_step (
    .rem     (rem),
    .quo     (quo),
    .dvs     (dvs),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  assign busy  = (state != S_IDLE);
  assign stall = (start & (state == S_IDLE) & ~flush)
               | (state == S_PREP) | (state == S_RUN) | (state == S_FIX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      done       <= 1'b0;
      q          <= '0;
      r          <= '0;
      dividend_l <= '0;
      divisor_l  <= '0;
      sign_l     <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      rem        <= '0;
      quo        <= '0;
      dvs        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            dividend_l <= dividend;
            divisor_l  <= divisor;
            sign_l     <= sign;
            neg_q      <= sign & (dividend[DIV_W-1] ^ divisor[DIV_W-1]);
            neg_r      <= sign & dividend[DIV_W-1];
            state      <= S_PREP;
          end
        end
        S_PREP: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            rem <= '0;
            quo <= cond_neg(dividend_l, neg_r);
            dvs <= cond_neg(divisor_l, sign_l & divisor_l[DIV_W-1]);
            cnt <= '0;
            // Zero divisor skips iteration and commits the fixed result directly.
            if (divisor_l == '0) begin
              q     <= DIV0_QUOT;
              r     <= dividend_l;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(DIV_ITERS - 1)) begin
              state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            q     <= cond_neg(quo, neg_q);
            r     <= cond_neg(rem, neg_r);
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed and randomised checks of div_seq_ctrl against a scoreboard of expected quotient/remainder.
module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sign;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_q = 32'h0;
  logic [31:0] last_r = 32'h0;

  always #5 clk = ~clk;

  div_seq_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sign     (sign),
    .dividend (dividend),
    .divisor  (divisor),
    .flush    (flush),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .q        (q),
    .r        (r)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eq, output logic [31:0] er);
    if (b == 32'h0) begin
      eq = 32'hFFFF_FFFF;
      er = a;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        eq = 32'h8000_0000;
        er = 32'h0;
      end else begin
        eq = $signed(a) / $signed(b);
        er = $signed(a) % $signed(b);
      end
    end else begin
      eq = a / b;
      er = a % b;
    end
  endfunction

  task automatic drive_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er);
    sign     = s;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back({eq, er});
  endtask

  // Called in cycle 0 (start high, DUT idle); returns at the negedge of the done cycle.
  task automatic wait_done(input int lat, input string tag);
    int   cyc = 0;
    logic found = 1'b0;
    exp_t e;
    #1;
    check({tag, "_stall_c0"}, {31'b0, stall}, 32'd1);
    while (cyc < 100 && !found) begin
      cycle();
      cyc++;
      if (done) found = 1'b1;
      else check({tag, "_stall_busy"}, {31'b0, stall}, 32'd1);
    end
    if (!found) begin
      errors++;
      $display("FAIL %s_timeout observed no done expected done within 100 cycles", tag);
      return;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(lat));
    check({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_sb observed done expected no result pending", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_q"}, q, e.q);
      check({tag, "_r"}, r, e.r);
      last_q = e.q;
      last_r = e.r;
    end
  endtask

  task automatic finish_op(input string tag);
    start = 1'b0;
    cycle();
    check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    check({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        s;
    logic [31:0] a, b, eq, er;

    reset = 1'b1; start = 1'b0; sign = 1'b0; dividend = '0; divisor = '0; flush = 1'b0;
    cycle();
    cycle();
    check("rst_busy",  {31'b0, busy},  32'd0);
    check("rst_done",  {31'b0, done},  32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_q", q, 32'h0);
    check("rst_r", r, 32'h0);
    reset = 1'b0;
    cycle();

    drive_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    wait_done(35, "divu_100_7");
    finish_op("divu_100_7");

    drive_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    wait_done(35, "div_m7_2");
    finish_op("div_m7_2");

    drive_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    wait_done(35, "div_7_m2");
    finish_op("div_7_m2");

    drive_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
    wait_done(35, "div_ovf");
    finish_op("div_ovf");

    drive_op(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'h0);
    wait_done(35, "divu_max_1");
    finish_op("divu_max_1");

    // Divide-by-zero, then a back-to-back second one with start held through DONE.
    drive_op(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
    wait_done(2, "divu_5_0");
    drive_op(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
    cycle();
    check("b2b_idle_done", {31'b0, done}, 32'd0);
    check("b2b_idle_busy", {31'b0, busy}, 32'd0);
    wait_done(2, "div_m5_0");
    finish_op("div_m5_0");

    // Flush at RUN iteration 10: no done, results unchanged.
    sign = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    repeat (12) cycle();
    check("flush_pre_busy", {31'b0, busy}, 32'd1);
    flush = 1'b1; start = 1'b0;
    cycle();
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    check("flush_q", q, last_q);
    check("flush_r", r, last_r);
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("flush_no_done", {31'b0, done}, 32'd0);
    end
    drive_op(1'b0, 32'd9, 32'd4, 32'd2, 32'd1);
    wait_done(35, "divu_9_4");
    finish_op("divu_9_4");

    // Flush in IDLE blocks acceptance.
    drive_op(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0);
    flush = 1'b1;
    #1;
    check("idle_flush_stall", {31'b0, stall}, 32'd0);
    cycle();
    check("idle_flush_busy", {31'b0, busy}, 32'd0);
    flush = 1'b0;
    wait_done(35, "divu_1000_10");
    // Flush during DONE leaves the committed result in place.
    flush = 1'b1; start = 1'b0;
    cycle();
    check("done_flush_q", q, 32'd100);
    check("done_flush_r", r, 32'd0);
    check("done_flush_busy", {31'b0, busy}, 32'd0);
    flush = 1'b0;
    cycle();

    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? $urandom_range(1, 15) : $urandom;
      if (i == 4) b = 32'h0;
      s = (i % 2 == 1);
      model(s, a, b, eq, er);
      drive_op(s, a, b, eq, er);
      wait_done((b == 32'h0) ? 2 : 35, "rand");
      finish_op("rand");
    end

    // Reset mid-RUN with start held; the op is accepted right after reset drops.
    sign = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    repeat (10) cycle();
    reset = 1'b1;
    dividend = 32'd9; divisor = 32'd4;
    cycle();
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_q", q, 32'h0);
    check("midrst_r", r, 32'h0);
    reset = 1'b0;
    sb.push_back({32'd2, 32'd1});
    wait_done(35, "post_rst");
    finish_op("post_rst");

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
# div_seq_ctrl

Multi-cycle sequencer for the EX-stage integer divider of the 54-instruction MIPS pipeline; executes DIV/DIVU as a 32-iteration restoring shift-subtract over registered state instead of one combinational cascade. Accepts a request from EX, stalls the pipeline while iterating, and returns quotient (LO) and remainder (HI) with a one-cycle done pulse. Supports pipeline flush (cancel) and a divide-by-zero fast path.

## Interface
- DIV_ITERS, 32, number of shift-subtract iterations (equals operand width)
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  request level; sampled only in IDLE; EX holds it until done
- sign  in  1  1 = DIV (signed), 0 = DIVU; sampled with start
- dividend  in  32  sampled with start
- divisor  in  32  sampled with start
- flush  in  1  cancel in-flight operation
- busy  out  1  1 in any state except IDLE
- stall  out  1  combinational: (start & IDLE & ~flush) | PREP | RUN | FIX
- done  out  1  one-cycle pulse, results valid
- q  out  32  quotient, registered, held until next completed op
- r  out  32  remainder, registered, held until next completed op

## Operation
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE: if start & ~flush, latch operands, sign, neg_q = sign & (dividend[31]^divisor[31]), neg_r = sign & dividend[31] -> PREP.
- PREP: rem=0; quo=|dividend| (two's-complement negate when sign & dividend[31]), dvs=|divisor| likewise; iteration counter=0. If divisor==0 -> DONE with q=32'hFFFFFFFF, r=raw dividend (both signed and unsigned); else -> RUN.
- RUN: one iteration per cycle: {rem,quo} shifted left 1; if rem >= dvs then rem -= dvs, quo[0]=1. Counter increments; after iteration DIV_ITERS-1 -> FIX.
- FIX: q = neg_q ? -quo : quo; r = neg_r ? -rem : rem (32-bit wrap) -> DONE.
- DONE: done=1 for this cycle only; start ignored; -> IDLE.
- Arithmetic is 32-bit unsigned on magnitudes; rem needs 33 bits for the compare. 0x80000000 magnitude is 0x80000000 unsigned; 0x80000000 / -1 signed yields q=0x80000000, r=0 (wrap, no trap).
- flush: in PREP/RUN/FIX, next state IDLE, no done, q/r unchanged. In IDLE, flush blocks acceptance. In DONE, flush has no effect (result already committed).
- reset beats flush beats start.

## Timing
- Reset: state IDLE, busy=0, done=0, q=0, r=0, counter=0.
- Normal latency: start accepted at edge E0; PREP cycle after E0, RUN 32 cycles, FIX 1, DONE 1; done high in the 35th cycle after acceptance.
- Divide-by-zero: done high in 2nd cycle after acceptance.
- stall falls in the DONE cycle so EX advances that edge; EX drops start the following cycle. start still high in IDLE after DONE starts a new operation (back-to-back divides).
- q/r change only on entry to DONE.

## Structure
- Shared package div_pkg: state enum type, DIV_ITERS, DIV_LATENCY=35, DIV0_LATENCY=2, DIV0_QUOT=32'hFFFFFFFF.
- Sub-module div_step: combinational single restoring iteration (in rem/quo/dvs, out next rem/quo); instantiated once inside the RUN datapath.
- FSM, counter, operand/sign registers, fixup negation in div_seq_ctrl.

## Test plan
- DIVU 100/7 -> done at cycle 35, q=14, r=2; stall high cycles 0-34, low at 35.
- DIV -7/2 -> q=32'hFFFFFFFD, r=32'hFFFFFFFF; DIV 7/-2 -> q=32'hFFFFFFFD, r=1.
- DIV 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; DIVU 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
- DIVU 5/0 -> done at cycle 2, q=32'hFFFFFFFF, r=5; DIV -5/0 -> r=32'hFFFFFFFB.
- DIVU 100/7 then flush at RUN iteration 10 -> IDLE next cycle, no done, q/r keep prior values; following DIVU 9/4 -> q=2, r=1.
- reset asserted mid-RUN -> next cycle busy=0, done=0, q=0, r=0; start held high through reset accepted the cycle after reset deasserts.
